gtest_objection_ctrl: RTL and testbench

GTEST_OBJECTION_CTRL -- requirements
Module: gtest_objection_ctrl

---
 rtl/gtest_objection_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_gtest_objection_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/gtest_objection_ctrl.sv
// Objection-based test controller: tracks per-channel objection counts,
// sequences IDLE -> INIT -> RUN <-> DRAIN -> DONE, counts warning/error
// reports and produces the final pass/fail verdict.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   start              begins a test from IDLE or DONE
//   raise, drop        per-channel objection pulses (N_CH bits)
//   timeout_limit      max RUN+DRAIN cycles, 0 disables
//   rpt_valid, rpt_sev report strobe and severity (0 info .. 3 fatal)
//   state, active      FSM encoding and RUN/DRAIN indicator
//   ch_busy, total_obj per-channel nonzero flags and count sum
//   warn_cnt, err_cnt  saturating report counters
//   done, pass, fail, timed_out, underflow, overflow  status flags
module gtest_objection_ctrl #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned INIT_CYCLES  = 10,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned TIMEOUT_W    = 16,
  localparam int unsigned TOT_W       = CNT_W + $clog2(N_CH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_CH-1:0]      raise,
  input  logic [N_CH-1:0]      drop,
  input  logic [TIMEOUT_W-1:0] timeout_limit,
  input  logic                 rpt_valid,
  input  logic [1:0]           rpt_sev,
  output logic [2:0]           state,
  output logic                 active,
  output logic [N_CH-1:0]      ch_busy,
  output logic [TOT_W-1:0]     total_obj,
  output logic [15:0]          warn_cnt,
  output logic [15:0]          err_cnt,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timed_out,
  output logic                 underflow,
  output logic                 overflow
);

  localparam int unsigned PH_MAX = (INIT_CYCLES > DRAIN_CYCLES) ? INIT_CYCLES : DRAIN_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                         state_q, state_d;
  logic [PH_W-1:0]                ph_q;
  logic [TIMEOUT_W-1:0]           cyc_q, cyc_inc;
  logic [N_CH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
  logic [15:0]                    warn_q, err_q;
  logic                           ran_q, fatal_q, timed_out_q, underflow_q, overflow_q;
  logic                           uf_hit, of_hit;
  logic                           accept, in_active, fatal_in, cyc_hit;
  logic                           ph_clr, ph_inc, entry_clr, to_set;
  logic [TOT_W-1:0]               tot_c;
  logic [N_CH-1:0]                busy_c;
  logic                           pass_ok;

  assign accept    = (state_q == S_INIT) || (state_q == S_RUN) || (state_q == S_DRAIN);
  assign in_active = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign fatal_in  = accept && rpt_valid && (rpt_sev == 2'd3);

  // Cycle counter saturates so a long disabled-timeout run never wraps
  // into a false match.
  assign cyc_inc = (cyc_q == '1) ? cyc_q : cyc_q + TIMEOUT_W'(1);
  assign cyc_hit = in_active && (timeout_limit != '0) && (cyc_inc == timeout_limit);

  // Next per-channel counts with saturation/underflow detection.
  always_comb begin
    cnt_d  = cnt_q;
    uf_hit = 1'b0;
    of_hit = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (raise[i] && !drop[i]) begin
        if (cnt_q[i] == CNT_MAX) of_hit = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (drop[i] && !raise[i]) begin
        if (cnt_q[i] == '0) uf_hit = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Sum and nonzero flags of the registered counts.
  always_comb begin
    tot_c  = '0;
    busy_c = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      tot_c     = tot_c + TOT_W'(cnt_q[i]);
      busy_c[i] = |cnt_q[i];
    end
  end

  // Next-state logic; fatal beats timeout beats drain handling.
  always_comb begin
    state_d   = state_q;
    ph_clr    = 1'b0;
    ph_inc    = 1'b0;
    entry_clr = 1'b0;
    to_set    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_INIT;
          entry_clr = 1'b1;
          ph_clr    = 1'b1;
        end
      end
      S_INIT: begin
        if (ph_q == PH_W'(INIT_CYCLES - 1)) state_d = S_RUN;
        else                                ph_inc  = 1'b1;
      end
      S_RUN: begin
        if (cyc_hit) begin
          state_d = S_DONE;
          to_set  = 1'b1;
        end else if ((tot_c == '0) && (raise == '0)) begin
          state_d = S_DRAIN;
          ph_clr  = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cyc_hit) begin
          state_d = S_DONE;
          to_set  = 1'b1;
        end else if ((raise != '0) || (tot_c != '0)) begin
          state_d = S_RUN;
        end else if (ph_q == PH_W'(DRAIN_CYCLES - 1)) begin
          state_d = S_DONE;
        end else begin
          ph_inc = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (fatal_in) begin
      state_d = S_DONE;
      to_set  = 1'b0;
    end
  end

  // State, counts, report counters and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ph_q        <= '0;
      cyc_q       <= '0;
      cnt_q       <= '0;
      warn_q      <= '0;
      err_q       <= '0;
      ran_q       <= 1'b0;
      fatal_q     <= 1'b0;
      timed_out_q <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ph_clr)      ph_q <= '0;
      else if (ph_inc) ph_q <= ph_q + PH_W'(1);
      if (entry_clr) begin
        cyc_q       <= '0;
        cnt_q       <= '0;
        warn_q      <= '0;
        err_q       <= '0;
        ran_q       <= 1'b0;
        fatal_q     <= 1'b0;
        timed_out_q <= 1'b0;
        underflow_q <= 1'b0;
        overflow_q  <= 1'b0;
      end else if (accept) begin
        cnt_q <= cnt_d;
        if (uf_hit)        underflow_q <= 1'b1;
        if (of_hit)        overflow_q  <= 1'b1;
        if (raise != '0)   ran_q       <= 1'b1;
        if (to_set)        timed_out_q <= 1'b1;
        if (in_active)     cyc_q       <= cyc_inc;
        if (rpt_valid && (rpt_sev == 2'd1) && (warn_q != 16'hFFFF)) warn_q <= warn_q + 16'd1;
        if (rpt_valid && rpt_sev[1] && (err_q != 16'hFFFF))         err_q  <= err_q + 16'd1;
        if (fatal_in)      fatal_q     <= 1'b1;
      end
    end
  end

  assign pass_ok = ran_q && (err_q == '0) && !timed_out_q && !fatal_q && !underflow_q && !overflow_q;

  assign state     = state_q;
  assign active    = in_active;
  assign ch_busy   = busy_c;
  assign total_obj = tot_c;
  assign warn_cnt  = warn_q;
  assign err_cnt   = err_q;
  assign done      = (state_q == S_DONE);
  assign pass      = done && pass_ok;
  assign fail      = done && !pass_ok;
  assign timed_out = timed_out_q;
  assign underflow = underflow_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_gtest_objection_ctrl.sv
// Scoreboard bench for gtest_objection_ctrl: directed stimulus pushes
// hand-computed expected observations; a negedge monitor pops and compares.
module tb_gtest_objection_ctrl;

  localparam int unsigned N_CH = 4;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned TW = 16;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] INIT  = 3'd1;
  localparam logic [2:0] RUN   = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic            clk = 1'b0;
  logic            rst, start, rpt_valid;
  logic [3:0]      raise, drop;
  logic [TW-1:0]   timeout_limit;
  logic [1:0]      rpt_sev;
  logic [2:0]      state;
  logic            active, done, pass, fail, timed_out, underflow, overflow;
  logic [3:0]      ch_busy;
  logic [4:0]      total_obj;
  logic [15:0]     warn_cnt, err_cnt;

  gtest_objection_ctrl #(
    .N_CH(N_CH), .CNT_W(CNT_W), .INIT_CYCLES(10), .DRAIN_CYCLES(4), .TIMEOUT_W(TW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .raise(raise), .drop(drop),
    .timeout_limit(timeout_limit), .rpt_valid(rpt_valid), .rpt_sev(rpt_sev),
    .state(state), .active(active), .ch_busy(ch_busy), .total_obj(total_obj),
    .warn_cnt(warn_cnt), .err_cnt(err_cnt), .done(done), .pass(pass), .fail(fail),
    .timed_out(timed_out), .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  st;
    logic        active, done, pass, fail, to, uf, of;
    logic [4:0]  total;
    logic [3:0]  busy;
    logic [15:0] warn, err;
  } obs_t;

  typedef struct {
    string name;
    obs_t  v;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  rec_t cur;
  obs_t got;

  function automatic obs_t mk(input logic [2:0] st, input logic [4:0] tot, input logic [3:0] busy,
                              input logic [15:0] w, input logic [15:0] e,
                              input logic p, input logic f, input logic to,
                              input logic uf, input logic of);
    obs_t m;
    m.st = st; m.active = (st == RUN) || (st == DRAIN); m.done = (st == DONE);
    m.pass = p; m.fail = f; m.to = to; m.uf = uf; m.of = of;
    m.total = tot; m.busy = busy; m.warn = w; m.err = e;
    return m;
  endfunction

  task automatic expect_obs(input string n, input obs_t v);
    rec_t r;
    r.name = n;
    r.v = v;
    exp_q.push_back(r);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  // Monitor: compare one expected observation per cycle, away from the edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      got.st = state; got.active = active; got.done = done; got.pass = pass;
      got.fail = fail; got.to = timed_out; got.uf = underflow; got.of = overflow;
      got.total = total_obj; got.busy = ch_busy; got.warn = warn_cnt; got.err = err_cnt;
      checks++;
      if (got !== cur.v) begin
        errors++;
        $display("FAIL %s: got st=%0d act=%b dn=%b p=%b f=%b to=%b uf=%b of=%b tot=%0d busy=%b w=%0d e=%0d | exp st=%0d act=%b dn=%b p=%b f=%b to=%b uf=%b of=%b tot=%0d busy=%b w=%0d e=%0d",
                 cur.name, got.st, got.active, got.done, got.pass, got.fail, got.to, got.uf, got.of,
                 got.total, got.busy, got.warn, got.err,
                 cur.v.st, cur.v.active, cur.v.done, cur.v.pass, cur.v.fail, cur.v.to, cur.v.uf,
                 cur.v.of, cur.v.total, cur.v.busy, cur.v.warn, cur.v.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running exp finished");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; raise = '0; drop = '0; timeout_limit = '0;
    rpt_valid = 1'b0; rpt_sev = 2'd0;
    tick(2);
    expect_obs("reset", mk(IDLE, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    tick(1);
    expect_obs("idle_hold", mk(IDLE, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));

    // Single objection on ch0, dropped 5 cycles after the raise.
    do_start();
    expect_obs("a_init_entry", mk(INIT, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tick(9);
    expect_obs("a_init_last", mk(INIT, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    raise = 4'b0001; tick(1); raise = '0;
    expect_obs("a_run_entry", mk(RUN, 1, 4'b0001, 0, 0, 0, 0, 0, 0, 0));
    tick(4);
    drop = 4'b0001; tick(1); drop = '0;
    expect_obs("a_total_zero", mk(RUN, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tick(1);
    expect_obs("a_drain_entry", mk(DRAIN, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tick(3);
    expect_obs("a_drain_last", mk(DRAIN, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tick(1);
    expect_obs("a_done_pass", mk(DONE, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
    raise = 4'b0100; drop = 4'b0010; rpt_valid = 1'b1; rpt_sev = 2'd2;
    tick(1);
    raise = '0; drop = '0; rpt_valid = 1'b0; rpt_sev = 2'd0;
    expect_obs("a_done_ignores_inputs", mk(DONE, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 0));

    // Restart from DONE with no raises: warnings counted, verdict fail.
    do_start();
    expect_obs("b_init_clears", mk(INIT, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    rpt_valid = 1'b1; rpt_sev = 2'd1; tick(1);
    rpt_sev = 2'd0; tick(1);
    rpt_valid = 1'b0;
    expect_obs("b_warn_count", mk(INIT, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0));
    tick(8);
    expect_obs("b_run_empty", mk(RUN, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0));
    tick(1);
    expect_obs("b_drain", mk(DRAIN, 0, 4'b0000, 1, 0, 0, 0, 0, 0, 0));
    tick(4);
    expect_obs("b_done_no_tests", mk(DONE, 0, 4'b0000, 1, 0, 0, 1, 0, 0, 0));

    // Raise during the second DRAIN cycle returns to RUN.
    do_start();
    tick(9);
    raise = 4'b0010; tick(1); raise = '0;
    expect_obs("c_run_ch1", mk(RUN, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0));
    drop = 4'b0010; tick(1); drop = '0;
    tick(1);
    expect_obs("c_drain1", mk(DRAIN, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tick(1);
    expect_obs("c_drain2", mk(DRAIN, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    raise = 4'b0010; tick(1); raise = '0;
    expect_obs("c_back_to_run", mk(RUN, 1, 4'b0010, 0, 0, 0, 0, 0, 0, 0));
    drop = 4'b0010; tick(1); drop = '0;
    tick(1);
    tick(3);
    expect_obs("c_full_window", mk(DRAIN, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    tick(1);
    expect_obs("c_done_pass", mk(DONE, 0, 4'b0000, 0, 0, 1, 0, 0, 0, 0));

    // Timeout after 20 RUN cycles with ch2 never dropped.
    timeout_limit = 16'd20;
    do_start();
    tick(9);
    raise = 4'b0100; tick(1); raise = '0;
    expect_obs("d_run", mk(RUN, 1, 4'b0100, 0, 0, 0, 0, 0, 0, 0));
    tick(19);
    expect_obs("d_run_cycle20", mk(RUN, 1, 4'b0100, 0, 0, 0, 0, 0, 0, 0));
    tick(1);
    expect_obs("d_timeout", mk(DONE, 1, 4'b0100, 0, 0, 0, 1, 1, 0, 0));
    timeout_limit = '0;

    // Underflow on ch3, then overflow on ch0 (CNT_W=2 saturates at 3).
    do_start();
    drop = 4'b1000; tick(1); drop = '0;
    raise = 4'b0001; tick(4); raise = '0;
    expect_obs("e_sat_uf_of", mk(INIT, 3, 4'b0001, 0, 0, 0, 0, 0, 1, 1));
    tick(5);
    expect_obs("e_run", mk(RUN, 3, 4'b0001, 0, 0, 0, 0, 0, 1, 1));
    drop = 4'b0001; tick(3); drop = '0;
    expect_obs("e_empty", mk(RUN, 0, 4'b0000, 0, 0, 0, 0, 0, 1, 1));
    tick(5);
    expect_obs("e_done_fail", mk(DONE, 0, 4'b0000, 0, 0, 0, 1, 0, 1, 1));

    // Fatal report mid-RUN.
    do_start();
    tick(9);
    raise = 4'b0001; tick(1); raise = '0;
    tick(2);
    rpt_valid = 1'b1; rpt_sev = 2'd3; tick(1);
    rpt_valid = 1'b0; rpt_sev = 2'd0;
    expect_obs("f_fatal_done", mk(DONE, 1, 4'b0001, 0, 1, 0, 1, 0, 0, 0));

    // Reset mid-RUN, colliding with start/raise/report.
    do_start();
    tick(9);
    raise = 4'b0001; tick(1); raise = '0;
    rpt_valid = 1'b1; rpt_sev = 2'd1; tick(1);
    rpt_valid = 1'b0; rpt_sev = 2'd0;
    expect_obs("f_run_busy", mk(RUN, 1, 4'b0001, 1, 0, 0, 0, 0, 0, 0));
    rst = 1'b1; start = 1'b1; raise = 4'b1111; rpt_valid = 1'b1; rpt_sev = 2'd3;
    tick(1);
    expect_obs("f_rst_mid_run", mk(IDLE, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0; start = 1'b0; raise = '0; rpt_valid = 1'b0; rpt_sev = 2'd0;
    tick(1);
    expect_obs("f_idle_after_rst", mk(IDLE, 0, 4'b0000, 0, 0, 0, 0, 0, 0, 0));

    tick(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
